// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer accumulator controller.
// Holds the controller state encoding and the one-shot/periodic mode bits.
package timer_pkg;

   localparam int W_DEF     = 32;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic MODE_PERIODIC = 1'b1;
   localparam logic MODE_ONESHOT  = 1'b0;

endpackage

// File: rtl/timer_match_cmp.sv
// Next-value adder, period comparator and remainder subtractor for the accumulator loop.
// The add is carried at W+1 bits so a wrap past 2^W still registers as a match.
module timer_match_cmp #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_acc,
   input  logic [W-1:0] i_step,
   input  logic [W-1:0] i_period,
   output logic         o_match,
   output logic [W-1:0] o_rem
);

   logic [W:0] w_nxt;

   assign w_nxt   = {1'b0, i_acc} + {1'b0, i_step};
   assign o_match = (w_nxt >= {1'b0, i_period});
   // On a match the true remainder is below period, so the low W bits are exact.
   assign o_rem   = w_nxt[W-1:0] - i_period;

endmodule

// File: rtl/timer_acc_ctrl.sv
// Drives the external accumulator: loads zero on start, adds step each RUN cycle,
// and reloads the remainder whenever the next value reaches the period.
module timer_acc_ctrl
   import timer_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             stop,
   input  logic [W-1:0]     cfg_step,
   input  logic [W-1:0]     cfg_period,
   input  logic             cfg_periodic,
   input  logic             irq_clr,
   input  logic [W-1:0]     acc,
   output logic             acc_enable,
   output logic             acc_load,
   output logic [W-1:0]     acc_load_val,
   output logic [W-1:0]     acc_d,
   output logic             running,
   output logic             irq,
   output logic             cfg_err,
   output logic [CNT_W-1:0] match_cnt
);

   state_t           r_state;
   logic [W-1:0]     r_step;
   logic [W-1:0]     r_period;
   logic             r_periodic;
   logic             r_irq;
   logic             r_cfg_err;
   logic [CNT_W-1:0] r_match_cnt;

   logic             w_match;
   logic [W-1:0]     w_rem;
   logic             w_match_evt;
   logic             w_cfg_ok;

   timer_match_cmp #(.W(W)) u_cmp (
      .i_acc    (acc),
      .i_step   (r_step),
      .i_period (r_period),
      .o_match  (w_match),
      .o_rem    (w_rem)
   );

   assign w_match_evt = (r_state == RUN) && w_match;
   assign w_cfg_ok    = (cfg_period != '0) && (cfg_step < cfg_period);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_step      <= '0;
         r_period    <= '0;
         r_periodic  <= MODE_ONESHOT;
         r_irq       <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_match_cnt <= '0;
      end else begin
         // A match counts even when stop arrives in the same cycle.
         if (w_match_evt) begin
            r_irq       <= 1'b1;
            r_match_cnt <= r_match_cnt + 1'b1;
         end else if (irq_clr) begin
            r_irq <= 1'b0;
         end

         if (stop) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE, DONE: begin
                  if (start) begin
                     if (w_cfg_ok) begin
                        r_step      <= cfg_step;
                        r_period    <= cfg_period;
                        r_periodic  <= cfg_periodic;
                        r_cfg_err   <= 1'b0;
                        r_match_cnt <= '0;
                        r_state     <= LOAD;
                     end else begin
                        r_cfg_err <= 1'b1;
                     end
                  end
               end
               LOAD: r_state <= RUN;
               RUN: begin
                  if (w_match && (r_periodic == MODE_ONESHOT)) r_state <= DONE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign acc_enable   = (r_state == RUN);
   assign acc_load     = (r_state == LOAD) || w_match_evt;
   assign acc_load_val = w_match_evt ? w_rem : '0;
   assign acc_d        = r_step;
   assign running      = (r_state == LOAD) || (r_state == RUN);
   assign irq          = r_irq;
   assign cfg_err      = r_cfg_err;
   assign match_cnt    = r_match_cnt;

endmodule

// File: tb/tb_timer_acc_ctrl.sv
// Closed-loop bench: timer_acc_ctrl driving a behavioural 32-bit registered accumulator.
// Expected accumulator values come from closed-form arithmetic on step, period and cycle count.
module tb_timer_acc_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start, stop, cfg_periodic, irq_clr;
   logic [31:0] cfg_step, cfg_period;
   logic [31:0] acc;
   logic        acc_enable, acc_load, running, irq, cfg_err;
   logic [31:0] acc_load_val, acc_d;
   logic [15:0] match_cnt;
   logic        poke;
   logic [31:0] poke_val;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   timer_acc_ctrl #(.W(32), .CNT_W(16)) dut (
      .clk(clk), .resetn(resetn), .start(start), .stop(stop),
      .cfg_step(cfg_step), .cfg_period(cfg_period), .cfg_periodic(cfg_periodic),
      .irq_clr(irq_clr), .acc(acc), .acc_enable(acc_enable), .acc_load(acc_load),
      .acc_load_val(acc_load_val), .acc_d(acc_d), .running(running), .irq(irq),
      .cfg_err(cfg_err), .match_cnt(match_cnt)
   );

   // Behavioural accumulator; poke lets the bench place acc near the top of its range.
   always_ff @(posedge clk) begin
      if (!resetn)         acc <= '0;
      else if (poke)       acc <= poke_val;
      else if (acc_load)   acc <= acc_load_val;
      else if (acc_enable) acc <= acc + acc_d;
   end

   // Cycle k counts RUN cycles after start (k=0 is the first RUN cycle, acc=0).
   // Periodic: acc = k*step mod period, matches = floor(k*step/period).
   // One-shot: stops at the first k with k*step >= period, holding the remainder.
   function automatic void model(input int unsigned k, input logic [31:0] st,
                                 input logic [31:0] pd, input logic per,
                                 output logic [31:0] a, output longint unsigned c,
                                 output logic run);
      longint unsigned s, p, prod, k1;
      s    = 64'(st);
      p    = 64'(pd);
      prod = 64'(k) * s;
      if (per) begin
         a   = 32'(prod % p);
         c   = prod / p;
         run = 1'b1;
      end else if (s != 0 && prod >= p) begin
         k1  = (p + s - 1) / s;
         a   = 32'(k1 * s - p);
         c   = 1;
         run = 1'b0;
      end else begin
         a   = 32'(prod);
         c   = 0;
         run = 1'b1;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_start(input logic [31:0] st, input logic [31:0] pd, input logic per);
      cfg_step = st; cfg_period = pd; cfg_periodic = per; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick(); tick();
      checks++;
      if ({acc_enable, acc_load, running, irq, cfg_err} !== 5'b0 || acc_load_val !== 32'd0 ||
          acc_d !== 32'd0 || match_cnt !== 16'd0) begin
         $display("FAIL reset_outputs got en=%b ld=%b run=%b irq=%b err=%b lv=%h d=%h cnt=%0d required all 0",
                  acc_enable, acc_load, running, irq, cfg_err, acc_load_val, acc_d, match_cnt);
         failures++;
      end
      resetn = 1'b1;
      tick();
      checks++;
      if (running !== 1'b0 || acc !== 32'd0) begin
         $display("FAIL reset_idle got running=%b acc=%h required 0/0", running, acc);
         failures++;
      end
      $display("reset: done");
   endtask

   task automatic test_periodic();
      logic [31:0] exp_seq [11] = '{0, 3, 6, 9, 2, 5, 8, 1, 4, 7, 0};
      do_start(32'd3, 32'd10, 1'b1);
      tick();
      for (int k = 0; k <= 10; k++) begin
         checks++;
         if (acc !== exp_seq[k] || running !== 1'b1) begin
            $display("FAIL periodic_acc k=%0d got acc=%0d running=%b required %0d/1", k, acc, running, exp_seq[k]);
            failures++;
         end
         if (k < 10) tick();
      end
      checks++;
      if (match_cnt !== 16'd3 || irq !== 1'b1) begin
         $display("FAIL periodic_cnt got cnt=%0d irq=%b required 3/1", match_cnt, irq);
         failures++;
      end
      $display("periodic: step=3 period=10 cnt=%0d", match_cnt);
      do_stop();
   endtask

   task automatic test_oneshot();
      do_start(32'd3, 32'd10, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) tick();
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (acc !== 32'd2 || running !== 1'b0 || match_cnt !== 16'd1 || acc_enable !== 1'b0) begin
            $display("FAIL oneshot_hold i=%0d got acc=%0d running=%b cnt=%0d en=%b required 2/0/1/0",
                     i, acc, running, match_cnt, acc_enable);
            failures++;
         end
         tick();
      end
      $display("oneshot: held acc=%0d", acc);
   endtask

   task automatic test_cfg_err();
      do_start(32'd3, 32'd0, 1'b1);
      checks++;
      if (cfg_err !== 1'b1 || running !== 1'b0) begin
         $display("FAIL cfg_err_period0 got err=%b running=%b required 1/0", cfg_err, running);
         failures++;
      end
      do_start(32'd10, 32'd10, 1'b1);
      checks++;
      if (cfg_err !== 1'b1 || running !== 1'b0 || acc !== 32'd2) begin
         $display("FAIL cfg_err_step_ge got err=%b running=%b acc=%0d required 1/0/2", cfg_err, running, acc);
         failures++;
      end
      do_start(32'd3, 32'd10, 1'b1);
      checks++;
      if (cfg_err !== 1'b0 || running !== 1'b1 || match_cnt !== 16'd0) begin
         $display("FAIL cfg_err_clear got err=%b running=%b cnt=%0d required 0/1/0", cfg_err, running, match_cnt);
         failures++;
      end
      do_stop();
      $display("cfg_err: done");
   endtask

   task automatic test_overflow();
      logic [31:0] ea;
      longint unsigned ec;
      logic er;
      do_start(32'h20, 32'hFFFF_FFF0, 1'b1);
      tick();
      poke = 1'b1; poke_val = 32'hFFFF_FFE0;
      tick();
      poke = 1'b0;
      checks++;
      if (acc_load !== 1'b1 || acc_load_val !== 32'h10) begin
         $display("FAIL overflow_rem got ld=%b val=%h required 1/00000010", acc_load, acc_load_val);
         failures++;
      end
      tick();
      checks++;
      if (acc !== 32'h10 || match_cnt !== 16'd1 || irq !== 1'b1) begin
         $display("FAIL overflow_acc got acc=%h cnt=%0d irq=%b required 00000010/1/1", acc, match_cnt, irq);
         failures++;
      end
      do_stop();
      do_start(32'hFFFF_FFE0, 32'hFFFF_FFF0, 1'b1);
      tick();
      tick(); tick();
      model(2, 32'hFFFF_FFE0, 32'hFFFF_FFF0, 1'b1, ea, ec, er);
      checks++;
      if (acc !== ea || match_cnt !== 16'(ec)) begin
         $display("FAIL overflow_bigstep got acc=%h cnt=%0d required %h/%0d", acc, match_cnt, ea, ec);
         failures++;
      end
      do_stop();
      $display("overflow: done");
   endtask

   task automatic test_irq_clr();
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
      checks++;
      if (irq !== 1'b0) begin
         $display("FAIL irq_clr_idle got irq=%b required 0", irq);
         failures++;
      end
      do_start(32'd3, 32'd10, 1'b1);
      tick();
      for (int k = 0; k < 4; k++) tick();
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
      checks++;
      if (irq !== 1'b0 || acc !== 32'd5) begin
         $display("FAIL irq_clr_nomatch got irq=%b acc=%0d required 0/5", irq, acc);
         failures++;
      end
      tick();
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
      checks++;
      if (irq !== 1'b1 || acc !== 32'd1) begin
         $display("FAIL irq_clr_match got irq=%b acc=%0d required 1/1", irq, acc);
         failures++;
      end
      $display("irq_clr: done");
   endtask

   task automatic test_back_to_back();
      cfg_step = 32'd5; cfg_period = 32'd20; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (acc !== 32'd4 || running !== 1'b0 || acc_enable !== 1'b0 || match_cnt !== 16'd2 || acc_d !== 32'd3) begin
            $display("FAIL stop_start i=%0d got acc=%0d run=%b en=%b cnt=%0d d=%0d required 4/0/0/2/3",
                     i, acc, running, acc_enable, match_cnt, acc_d);
            failures++;
         end
         tick();
      end
      do_start(32'd3, 32'd10, 1'b1);
      tick(); tick(); tick();
      resetn = 1'b0;
      tick();
      checks++;
      if ({acc_enable, acc_load, running, irq, cfg_err} !== 5'b0 || acc_load_val !== 32'd0 ||
          acc_d !== 32'd0 || match_cnt !== 16'd0 || acc !== 32'd0) begin
         $display("FAIL midrun_reset got en=%b ld=%b run=%b irq=%b err=%b cnt=%0d acc=%h required all 0",
                  acc_enable, acc_load, running, irq, cfg_err, match_cnt, acc);
         failures++;
      end
      resetn = 1'b1;
      tick();
      checks++;
      if (running !== 1'b0 || acc !== 32'd0) begin
         $display("FAIL midrun_reset_idle got running=%b acc=%h required 0/0", running, acc);
         failures++;
      end
      $display("back_to_back: done");
   endtask

   task automatic test_random();
      logic [31:0] st, pd, ea;
      logic per, er;
      longint unsigned ec;
      int unsigned n;
      for (int t = 0; t < 10; t++) begin
         irq_clr = 1'b1; tick(); irq_clr = 1'b0;
         if (t % 3 == 2) pd = $urandom | 32'h8000_0000;
         else            pd = 32'($urandom_range(200, 1));
         st  = $urandom % pd;
         per = 1'($urandom);
         n   = $urandom_range(40, 3);
         do_start(st, pd, per);
         tick();
         for (int unsigned k = 0; k <= n; k++) begin
            model(k, st, pd, per, ea, ec, er);
            checks++;
            if (acc !== ea || match_cnt !== 16'(ec) || running !== er || irq !== (ec != 0)) begin
               $display("FAIL random_run t=%0d k=%0d got acc=%h cnt=%0d run=%b irq=%b required %h/%0d/%b/%b",
                        t, k, acc, match_cnt, running, irq, ea, 16'(ec), er, (ec != 0));
               failures++;
            end
            if (k < n) tick();
         end
         do_stop();
         model(n + 1, st, pd, per, ea, ec, er);
         checks++;
         if (acc !== ea || match_cnt !== 16'(ec) || running !== 1'b0) begin
            $display("FAIL random_stop t=%0d got acc=%h cnt=%0d run=%b required %h/%0d/0",
                     t, acc, match_cnt, running, ea, 16'(ec));
            failures++;
         end
         do_start(pd + 32'($urandom_range(5, 0)), pd, per);
         checks++;
         if (cfg_err !== 1'b1 || running !== 1'b0 || acc !== ea) begin
            $display("FAIL random_reject t=%0d got err=%b run=%b acc=%h required 1/0/%h", t, cfg_err, running, acc, ea);
            failures++;
         end
         $display("random t=%0d step=%h period=%h periodic=%b cycles=%0d", t, st, pd, per, n);
      end
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; stop = 1'b0; irq_clr = 1'b0;
      cfg_step = '0; cfg_period = '0; cfg_periodic = 1'b0;
      poke = 1'b0; poke_val = '0;
      @(negedge clk);
      test_reset();
      test_periodic();
      test_oneshot();
      test_cfg_err();
      test_overflow();
      test_irq_clr();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
